filter2d_ctrl: RTL



---
 rtl/filter2d_ctrl_pkg.sv | 26 ++
 rtl/filter_coeff_bank.sv | 51 +++++
 rtl/filter2d_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/filter2d_ctrl_pkg.sv
// Shared definitions for the frame-synchronous filter configuration controller:
// stream dtype codes, FSM state encoding and the frame-count type.

`ifndef DTYPES_DEFINED
`define DTYPES_DEFINED
`define DTYPE_WIDTH        4
`define DTYPE_DATA         4'h0
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_LINE_START   4'h3
`endif

package filter2d_ctrl_pkg;

    // Width of the one-shot frame counter and of cfg_nframes.
    localparam int FRAME_CNT_WIDTH = 16;

    typedef logic [FRAME_CNT_WIDTH-1:0] frame_cnt_t;

    // Commit FSM: either nothing is waiting, or a commit waits for a frame start.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/filter_coeff_bank.sv
// Staging coefficient registers with an indexed write port, plus the live
// packed coefficient bus that is loaded from staging on an apply strobe.

module filter_coeff_bank #(
    parameter int                     KERNEL_SIZE = 3,
    parameter int                     COEFF_WIDTH = 8,
    parameter int                     ADDR_WIDTH  = 4,
    parameter logic [COEFF_WIDTH-1:0] RESET_COEFF = 8'h80
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               we,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic [COEFF_WIDTH-1:0]             wdata,
    input  logic                               apply,
    output logic [KERNEL_SIZE*COEFF_WIDTH-1:0] coeffs
);

    logic [COEFF_WIDTH-1:0] staging [KERNEL_SIZE];

    // Host writes land in staging; out-of-range indices match no word and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: staging is a handful of flops, not a RAM, so it can and must be
            // reset; a real memory macro would get no reset branch here.
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                staging[i] <= RESET_COEFF;
            end
        end else if (we) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                if (addr == ADDR_WIDTH'(i)) begin
                    staging[i] <= wdata;
                end
            end
        end
    end

    // Apply copies the whole staging set to the live bus in a single edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            coeffs <= {KERNEL_SIZE{RESET_COEFF}};
        end else if (apply) begin
            // NOTE: non-blocking assignment means staging is read before any write on
            // this same edge lands, so a concurrent host write reaches staging only.
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] <= staging[i];
            end
        end
    end

endmodule

// File: rtl/filter2d_ctrl.sv
// Frame-synchronous configuration controller: holds a host commit until the next
// frame-start beat, then applies coefficients/enable atomically, and optionally
// counts down N frames before dropping back to bypass.

module filter2d_ctrl
    import filter2d_ctrl_pkg::*;
#(
    parameter int                     KERNEL_SIZE = 3,
    parameter int                     COEFF_WIDTH = 8,
    parameter int                     ADDR_WIDTH  = 4,
    parameter logic [COEFF_WIDTH-1:0] RESET_COEFF = 8'h80
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               dvi,
    input  logic [`DTYPE_WIDTH-1:0]            dtypei,
    input  logic                               cfg_we,
    input  logic [ADDR_WIDTH-1:0]              cfg_addr,
    input  logic [COEFF_WIDTH-1:0]             cfg_wdata,
    input  logic                               cfg_enable,
    input  logic [FRAME_CNT_WIDTH-1:0]         cfg_nframes,
    input  logic                               cfg_commit,
    output logic [KERNEL_SIZE*COEFF_WIDTH-1:0] coeffs,
    output logic                               enable,
    output logic                               pending,
    output logic                               applied,
    output logic [FRAME_CNT_WIDTH-1:0]         frames_left
);

    state_t     state_q, state_d;
    logic       do_apply;
    logic       stg_en;
    frame_cnt_t stg_n;
    logic       fs, fe;

    assign fs = dvi && (dtypei == `DTYPE_FRAME_START);
    assign fe = dvi && (dtypei == `DTYPE_FRAME_END);

    filter_coeff_bank #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RESET_COEFF (RESET_COEFF)
    ) u_bank (
        .clk    (clk),
        .reset  (reset),
        .we     (cfg_we),
        .addr   (cfg_addr),
        .wdata  (cfg_wdata),
        .apply  (do_apply),
        .coeffs (coeffs)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and apply strobe; a commit arriving with the applying fs re-arms.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch forms.
        state_d  = state_q;
        do_apply = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                if (fs) begin
                    do_apply = 1'b1;
                    state_d  = cfg_commit ? ST_PENDING : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture of staged enable/frame count; the last commit before the apply wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_en <= 1'b0;
            stg_n  <= '0;
        end else if (cfg_commit) begin
            stg_en <= cfg_enable;
            stg_n  <= cfg_nframes;
        end
    end

    // Live enable, one-shot countdown and applied pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable      <= 1'b0;
            frames_left <= '0;
            applied     <= 1'b0;
        end else begin
            applied <= do_apply;
            if (do_apply) begin
                enable      <= stg_en;
                frames_left <= stg_en ? stg_n : '0;
            end else if (fe && enable && (frames_left != '0)) begin
                frames_left <= frames_left - frame_cnt_t'(1);
                if (frames_left == frame_cnt_t'(1)) begin
                    enable <= 1'b0;
                end
            end
        end
    end

    assign pending = (state_q == ST_PENDING);

endmodule
